// File: rtl/ram2e_phase_seq.sv
// Phase sequencer for the RAM2E card: recovers Apple IIe bus phase from PHI1 on
// C14M and drives the SDRAM slot counter, mode-register strobe, refresh enable and lock status.
module ram2e_phase_seq (
    input  logic       C14M,
    input  logic       nRST,
    input  logic       PHI1,
    output logic [3:0] S,
    output logic       MRSEn,
    output logic       RefEn,
    output logic       Locked,
    output logic       PhaseErr
);

    logic       phi1R_q,    phi1R_d;
    logic       phi1Seen_q, phi1Seen_d;
    logic       phi0Seen_q, phi0Seen_d;
    logic       first_q,    first_d;
    logic       locked_q,   locked_d;
    logic       phaseErr_q, phaseErr_d;
    logic       mrsEn_q,    mrsEn_d;
    logic [3:0] s_q,        s_d;
    logic [1:0] initS_q,    initS_d;
    logic [2:0] ref_q,      ref_d;
    logic [4:0] p_q,        p_d;
    logic [1:0] goodCnt_q,  goodCnt_d;

    logic qualEdge;
    logic periodOk;
    logic timeout;

    // A rising PHI1 edge only counts once both phases have been observed since reset,
    // so a card powered up mid-phase never syncs to a partial first half-cycle.
    assign qualEdge = PHI1 & ~phi1R_q & phi1Seen_q & phi0Seen_q;
    assign periodOk = (p_q == 5'd14) || (p_q == 5'd16);
    assign timeout  = ~qualEdge & first_q & (p_q == 5'd16);

    always_comb begin
        phi1R_d    = PHI1;
        phi1Seen_d = phi1Seen_q | PHI1;
        phi0Seen_d = phi0Seen_q | ~PHI1;
        first_d    = first_q;
        locked_d   = locked_q;
        phaseErr_d = 1'b0;
        goodCnt_d  = goodCnt_q;
        s_d        = s_q;
        initS_d    = initS_q;
        ref_d      = ref_q;
        p_d        = p_q;

        if (qualEdge) begin
            s_d = 4'd1;
        end else if ((s_q != 4'd0) && (s_q != 4'hF)) begin
            s_d = s_q + 4'd1;
        end

        if ((s_q == 4'd0) && (initS_q != 2'd3)) begin
            initS_d = initS_q + 2'd1;
        end
        mrsEn_d = (s_q == 4'd0) && (initS_q == 2'd1);

        if (qualEdge) begin
            ref_d = ref_q + 3'd1;
        end

        if (qualEdge) begin
            p_d = 5'd1;
        end else if (p_q != 5'd31) begin
            p_d = p_q + 5'd1;
        end

        // The first edge after reset only starts the measurement; later edges judge
        // the period just ended, and a missing edge is flagged once at P=16.
        if (qualEdge) begin
            if (!first_q) begin
                first_d = 1'b1;
            end else if (periodOk) begin
                if (goodCnt_q == 2'd3) begin
                    locked_d = 1'b1;
                end else begin
                    goodCnt_d = goodCnt_q + 2'd1;
                end
            end else begin
                phaseErr_d = 1'b1;
                locked_d   = 1'b0;
                goodCnt_d  = 2'd0;
            end
        end else if (timeout) begin
            phaseErr_d = 1'b1;
            locked_d   = 1'b0;
            goodCnt_d  = 2'd0;
        end
    end

    always_ff @(posedge C14M or negedge nRST) begin
        if (!nRST) begin
            phi1R_q    <= 1'b0;
            phi1Seen_q <= 1'b0;
            phi0Seen_q <= 1'b0;
            first_q    <= 1'b0;
            locked_q   <= 1'b0;
            phaseErr_q <= 1'b0;
            mrsEn_q    <= 1'b0;
            s_q        <= 4'd0;
            initS_q    <= 2'd0;
            ref_q      <= 3'd0;
            p_q        <= 5'd0;
            goodCnt_q  <= 2'd0;
        end else begin
            phi1R_q    <= phi1R_d;
            phi1Seen_q <= phi1Seen_d;
            phi0Seen_q <= phi0Seen_d;
            first_q    <= first_d;
            locked_q   <= locked_d;
            phaseErr_q <= phaseErr_d;
            mrsEn_q    <= mrsEn_d;
            s_q        <= s_d;
            initS_q    <= initS_d;
            ref_q      <= ref_d;
            p_q        <= p_d;
            goodCnt_q  <= goodCnt_d;
        end
    end

    assign S        = s_q;
    assign MRSEn    = mrsEn_q;
    assign RefEn    = (ref_q == 3'd7);
    assign Locked   = locked_q;
    assign PhaseErr = phaseErr_q;

endmodule
